seq_detect_fsm: RTL and testbench



---
 rtl/seq_detect_pkg.sv | 68 ++++++
 rtl/sat_counter.sv | 42 ++++
 rtl/seq_detect_fsm.sv | 133 +++++++++++++
 tb/tb_seq_detect_fsm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//   Elaboration-time helpers for the parametrised serial-pattern detector.
//   Nothing here produces hardware on its own; the functions are evaluated as
//   constants while the detector's next-state table is being built.
//
//   seq_state_w : number of state bits needed to count 0..pat_w matched bits.
//   seq_next    : next state after receiving bit b while k pattern bits are
//                 matched (k = pat_w means MATCH), including KMP fallback and
//                 the overlap/restart rule out of MATCH.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    localparam int unsigned PAT_W_MAX = 16;

    function automatic int unsigned seq_state_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // pattern[pat_w-1] is the first bit on the wire. Symbol i of the pattern
    // (0 = oldest) is therefore pattern[pat_w-1-i].
    function automatic int unsigned seq_next(
        input logic [15:0] pattern,
        input int unsigned pat_w,
        input bit          overlap,
        input int unsigned k,
        input bit          b
    );
        int unsigned kk;
        int unsigned len;
        int unsigned max_m;
        int unsigned result;
        bit          ok;
        logic [16:0] s;

        // Without overlap, leaving MATCH behaves exactly like leaving idle.
        kk = (k >= pat_w && !overlap) ? 0 : k;

        if (kk < pat_w && b == pattern[pat_w-1-kk]) begin
            return kk + 1;
        end

        // s = the kk matched symbols followed by the new bit, oldest at s[0].
        s = '0;
        for (int unsigned i = 0; i < kk; i++) begin
            s[i] = pattern[pat_w-1-i];
        end
        s[kk] = b;
        len   = kk + 1;

        // Longest proper prefix of the pattern that is a suffix of s.
        max_m  = (kk < pat_w) ? kk : pat_w - 1;
        result = 0;
        for (int unsigned m = max_m; m > 0 && result == 0; m--) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < m; j++) begin
                if (pattern[pat_w-1-j] != s[len-m+j]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                result = m;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter: adds one on each clock where inc_i is high until it
//   reaches all-ones, then holds. Cleared only by the asynchronous reset.
//
//   Parameters: W - counter width
//   Ports:
//     clk_i     in   rising-edge clock
//     resetn_i  in   asynchronous active-low reset
//     inc_i     in   increment request for this edge
//     cnt_o     out  [W-1:0] current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
//   Parametrised Moore detector for a serial bit pattern (MSB first). State is
//   the number of pattern bits currently matched; state PAT_W is MATCH and
//   drives the registered output flag. The next-state table is computed at
//   elaboration, so no pattern is stored at run time. Defaults reproduce the
//   legacy overlapping "101" detector.
//
//   Parameters:
//     PAT_W    pattern length, 2..16
//     PATTERN  pattern value, first received bit in the MSB
//     OVERLAP  1 = overlapping matches, 0 = restart search after a match
//     CNT_W    match counter width (only with SEQ_DETECT_MATCH_COUNT_EN)
//
//   Ports:
//     clk        in   rising-edge clock
//     resetn     in   asynchronous active-low reset
//     clear      in   synchronous return to idle, wins over in_valid
//     in_valid   in   qualifies in
//     in         in   serial data bit
//     out        out  high while the state is MATCH
//     match_cnt  out  [CNT_W-1:0] saturating match count
//                     (present only when SEQ_DETECT_MATCH_COUNT_EN is defined)
//
//   Build option: define SEQ_DETECT_MATCH_COUNT_EN to add the match counter.
// -----------------------------------------------------------------------------
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int unsigned      OVERLAP = 1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in,
    output logic             out
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int unsigned SW    = seq_state_w(PAT_W);
    localparam int unsigned NENT  = 2 ** SW;
    localparam int unsigned TBL_W = 2 * NENT * SW;

    localparam logic [SW-1:0] S_IDLE  = '0;
    localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);

    if (PAT_W < 2 || PAT_W > PAT_W_MAX || CNT_W < 1) begin : g_bad_params
        $error("seq_detect_fsm: PAT_W must be 2..16 and CNT_W at least 1");
    end

    // Entry (2*k + b) holds next(k, b). Rows for encodings above PAT_W are
    // left at zero; they are never used because such states are forced idle.
    function automatic logic [TBL_W-1:0] build_next_tbl();
        logic [TBL_W-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < NENT; k++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (k <= PAT_W) begin
                    t[(2*k+b)*SW +: SW] =
                        SW'(seq_next(16'(PATTERN), PAT_W, OVERLAP != 0, k, b != 0));
                end
            end
        end
        return t;
    endfunction

    function automatic logic [NENT-1:0] build_valid_mask();
        logic [NENT-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NENT; k++) begin
            m[k] = (k <= PAT_W);
        end
        return m;
    endfunction

    localparam logic [TBL_W-1:0] NEXT_TBL   = build_next_tbl();
    localparam logic [NENT-1:0]  VALID_MASK = build_valid_mask();

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          out_q;
    logic [31:0]   tbl_idx;

    always_comb begin
        tbl_idx = 32'({state_q, in});
        state_d = state_q;
        if (!VALID_MASK[state_q]) begin
            // Stray encodings recover even while stalled.
            state_d = S_IDLE;
        end else if (clear) begin
            state_d = S_IDLE;
        end else if (in_valid) begin
            state_d = NEXT_TBL[tbl_idx*SW +: SW];
        end
    end

    // The flag is registered from state_d so it equals (state_q == S_MATCH)
    // without any combinational path from in to out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= (state_d == S_MATCH);
        end
    end

    assign out = out_q;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic enter_match;

    assign enter_match = in_valid && !clear && (state_d == S_MATCH);

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk_i    (clk),
        .resetn_i (resetn),
        .inc_i    (enter_match),
        .cnt_o    (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
module tb_seq_detect_fsm;

    logic clk;
    logic resetn;
    logic clear;
    logic in_valid;
    logic in_bit;
    logic out_def;
    logic out_novl;
    logic out_p4;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic [1:0] cnt_def;
    logic [7:0] cnt_novl;
    logic [7:0] cnt_p4;
`endif

    int checks   = 0;
    int failures = 0;

    // Legacy-compatible detector ("101", overlapping); CNT_W shrunk to see saturation.
    seq_detect_fsm #(
        .CNT_W (2)
    ) u_def (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in        (in_bit),
        .out       (out_def)
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        ,
        .match_cnt (cnt_def)
`endif
    );

    seq_detect_fsm #(
        .OVERLAP (0)
    ) u_novl (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in        (in_bit),
        .out       (out_novl)
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        ,
        .match_cnt (cnt_novl)
`endif
    );

    seq_detect_fsm #(
        .PAT_W   (4),
        .PATTERN (4'b1101)
    ) u_p4 (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in        (in_bit),
        .out       (out_p4)
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        ,
        .match_cnt (cnt_p4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic apply(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", 32'(u_def.state_q), 32'd0);
        chk("reset_out_def", 32'(out_def), 32'd0);
        chk("reset_out_novl", 32'(out_novl), 32'd0);
        chk("reset_out_p4", 32'(out_p4), 32'd0);
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        chk("reset_cnt", 32'(cnt_def), 32'd0);
`endif
        resetn = 1'b1;

        // Default overlap: 1,0,1,0,1 -> S1,S2,S3,S2,S3
        apply(1, 1); chk("t1_b1_state", 32'(u_def.state_q), 32'd1); chk("t1_b1_out", 32'(out_def), 32'd0);
        apply(1, 0); chk("t1_b2_state", 32'(u_def.state_q), 32'd2); chk("t1_b2_out", 32'(out_def), 32'd0);
        apply(1, 1); chk("t1_b3_state", 32'(u_def.state_q), 32'd3); chk("t1_b3_out", 32'(out_def), 32'd1);
        apply(1, 0); chk("t1_b4_state", 32'(u_def.state_q), 32'd2); chk("t1_b4_out", 32'(out_def), 32'd0);
        apply(1, 1); chk("t1_b5_state", 32'(u_def.state_q), 32'd3); chk("t1_b5_out", 32'(out_def), 32'd1);
        // 1 from MATCH falls back to S1 in the legacy table
        apply(1, 1); chk("t1_b6_state", 32'(u_def.state_q), 32'd1); chk("t1_b6_out", 32'(out_def), 32'd0);

        // Non-overlapping: 1,0,1,0,1,1,0,1 -> out after bits 3 and 8 only
        pulse_reset();
        apply(1, 1); chk("t2_b1_out", 32'(out_novl), 32'd0);
        apply(1, 0); chk("t2_b2_out", 32'(out_novl), 32'd0);
        apply(1, 1); chk("t2_b3_out", 32'(out_novl), 32'd1);
        apply(1, 0); chk("t2_b4_out", 32'(out_novl), 32'd0);
        chk("t2_b4_state", 32'(u_novl.state_q), 32'd0);
        apply(1, 1); chk("t2_b5_out", 32'(out_novl), 32'd0);
        chk("t2_b5_out_overlap", 32'(out_def), 32'd1);
        apply(1, 1); chk("t2_b6_out", 32'(out_novl), 32'd0);
        apply(1, 0); chk("t2_b7_out", 32'(out_novl), 32'd0);
        apply(1, 1); chk("t2_b8_out", 32'(out_novl), 32'd1);

        // PAT_W=4, 1101: stream 1,1,1,0,1 -> states 1,2,2,3,4
        pulse_reset();
        apply(1, 1); chk("t3_b1_out", 32'(out_p4), 32'd0);
        apply(1, 1); chk("t3_b2_state", 32'(u_p4.state_q), 32'd2);
        apply(1, 1); chk("t3_b3_state", 32'(u_p4.state_q), 32'd2); chk("t3_b3_out", 32'(out_p4), 32'd0);
        apply(1, 0); chk("t3_b4_state", 32'(u_p4.state_q), 32'd3); chk("t3_b4_out", 32'(out_p4), 32'd0);
        apply(1, 1); chk("t3_b5_state", 32'(u_p4.state_q), 32'd4); chk("t3_b5_out", 32'(out_p4), 32'd1);

        // Stall: S2 held for 5 invalid cycles with in=1
        pulse_reset();
        apply(1, 1);
        apply(1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 1);
            chk("t4_stall_out", 32'(out_def), 32'd0);
        end
        chk("t4_stall_state", 32'(u_def.state_q), 32'd2);
        apply(1, 1); chk("t4_resume_out", 32'(out_def), 32'd1);
        apply(0, 0); chk("t4_hold_match1", 32'(out_def), 32'd1);
        apply(0, 1); chk("t4_hold_match2", 32'(out_def), 32'd1);
        chk("t4_hold_state", 32'(u_def.state_q), 32'd3);

        // Asynchronous reset between edges from S2
        pulse_reset();
        apply(1, 1);
        apply(1, 0);
        chk("t5_pre_state", 32'(u_def.state_q), 32'd2);
        resetn = 1'b0;
        #2;
        chk("t5_async_state", 32'(u_def.state_q), 32'd0);
        chk("t5_async_out", 32'(out_def), 32'd0);
        resetn = 1'b1;

        // Clear beats in_valid: S2 + (clear, valid, 1) -> S0, not S3
        apply(1, 1);
        apply(1, 0);
        clear = 1'b1;
        apply(1, 1);
        clear = 1'b0;
        chk("t5_clear_state", 32'(u_def.state_q), 32'd0);
        chk("t5_clear_out", 32'(out_def), 32'd0);
        apply(1, 1); chk("t5_after_clear_state", 32'(u_def.state_q), 32'd1);

`ifdef SEQ_DETECT_MATCH_COUNT_EN
        // Six overlapping 101 matches on 1010101010101 with CNT_W=2 saturate at 3
        pulse_reset();
        chk("t6_cnt_reset", 32'(cnt_def), 32'd0);
        apply(1, 1); apply(1, 0);
        apply(1, 1); chk("t6_m1", 32'(cnt_def), 32'd1);
        apply(1, 0); chk("t6_m1_hold", 32'(cnt_def), 32'd1);
        apply(1, 1); chk("t6_m2", 32'(cnt_def), 32'd2);
        apply(1, 0);
        apply(1, 1); chk("t6_m3", 32'(cnt_def), 32'd3);
        apply(1, 0);
        apply(1, 1); chk("t6_m4", 32'(cnt_def), 32'd3);
        apply(1, 0);
        apply(1, 1); chk("t6_m5", 32'(cnt_def), 32'd3);
        apply(1, 0);
        apply(1, 1); chk("t6_m6", 32'(cnt_def), 32'd3);
        chk("t6_novl_cnt", 32'(cnt_novl), 32'd3);
        chk("t6_p4_cnt", 32'(cnt_p4), 32'd0);
        clear = 1'b1;
        apply(1, 1);
        clear = 1'b0;
        chk("t6_clear_cnt", 32'(cnt_def), 32'd3);
        chk("t6_clear_state", 32'(u_def.state_q), 32'd0);
        pulse_reset();
        chk("t6_reset_cnt", 32'(cnt_def), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
